// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned PWM_STEPS  = 16;
  localparam int unsigned SEG_W      = 8;
  localparam int unsigned STEP_W     = $clog2(PWM_STEPS);
  localparam int unsigned DIGIT_W    = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {GUARD, ON, OFF} scan_state_t;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [STEP_W-1:0]  step_t;

  // One digit-code update as selected by the write arbiter
  typedef struct packed {
    digit_t           digit;
    logic [SEG_W-1:0] code;
  } seg_wr_t;

endpackage

// File: rtl/seg_wr_arbiter.sv
// Two-port round-robin write arbiter for the digit code register file.
module seg_wr_arbiter
  import seg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             p0_valid,
  input  digit_t           p0_digit,
  input  logic [SEG_W-1:0] p0_code,
  input  logic             p1_valid,
  input  digit_t           p1_digit,
  input  logic [SEG_W-1:0] p1_code,
  output logic             p0_ready_c,
  output logic             p1_ready_c,
  output logic             wr_en_c,
  output seg_wr_t          wr_c
);

  // ptr_q = 0 favours port 0 on contention, 1 favours port 1
  logic ptr_q;

  always_comb begin
    p0_ready_c = p0_valid && (!p1_valid || !ptr_q);
    p1_ready_c = p1_valid && (!p0_valid ||  ptr_q);
    wr_en_c    = p0_ready_c || p1_ready_c;
    wr_c       = p1_ready_c ? seg_wr_t'{digit: p1_digit, code: p1_code}
                            : seg_wr_t'{digit: p0_digit, code: p0_code};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (p0_ready_c) begin
      ptr_q <= 1'b1;
    end else if (p1_ready_c) begin
      ptr_q <= 1'b0;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with PWM brightness, guard step and
// round-robin code writes. Optional blink feature enabled by SEG_BLINK_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned SUB_DIV = 6250
`ifdef SEG_BLINK_EN
  , parameter int unsigned BLINK_SLOTS = 500
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic [DIGIT_W-1:0]    p0_digit,
  input  logic [SEG_W-1:0]      p0_code,
  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic [DIGIT_W-1:0]    p1_digit,
  input  logic [SEG_W-1:0]      p1_code,
  input  logic [STEP_W-1:0]     brightness,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  output logic [NUM_DIGITS-1:0] an,
  output logic [SEG_W-1:0]      ca,
  output logic                  slot_tick
);

  localparam int unsigned CNT_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;

  logic                  wr_en_c;
  seg_wr_t               wr_c;
  logic [SEG_W-1:0]      code_q [NUM_DIGITS];

  logic [CNT_W-1:0]      cyc_q, cyc_nxt;
  step_t                 step_q, step_nxt;
  digit_t                digit_q, digit_nxt;
  scan_state_t           state_q, state_nxt;
  logic                  cyc_end, slot_end, slot_start;

  logic [SEG_W-1:0]      sh_code_q, sh_code_nxt;
  step_t                 sh_bright_q, sh_bright_nxt;
  logic                  sh_blank_q, sh_blank_nxt;
  logic                  blank_live;

  logic [NUM_DIGITS-1:0] an_d;
  logic [SEG_W-1:0]      ca_d;
  logic                  tick_d;

  seg_wr_arbiter u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .p0_valid   (p0_valid),
    .p0_digit   (p0_digit),
    .p0_code    (p0_code),
    .p1_valid   (p1_valid),
    .p1_digit   (p1_digit),
    .p1_code    (p1_code),
    .p0_ready_c (p0_ready),
    .p1_ready_c (p1_ready),
    .wr_en_c    (wr_en_c),
    .wr_c       (wr_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) code_q[i] <= '0;
    end else if (wr_en_c) begin
      code_q[wr_c.digit] <= wr_c.code;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int unsigned BLINK_W = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blink_phase_q;

  // Free-running slot counter; phase flips every BLINK_SLOTS slots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (slot_end) begin
      if (blink_cnt_q == BLINK_W'(BLINK_SLOTS - 1)) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  assign blank_live = blank_mask[digit_q] | (blink_phase_q & blink_mask[digit_q]);
`else
  assign blank_live = blank_mask[digit_q];
`endif

  // Counter advance; outputs are registered from the next-cycle view
  always_comb begin
    cyc_end    = (cyc_q == CNT_W'(SUB_DIV - 1));
    slot_end   = cyc_end && (step_q == STEP_W'(PWM_STEPS - 1));
    slot_start = (cyc_q == '0) && (step_q == '0);
    cyc_nxt    = cyc_end ? '0 : cyc_q + CNT_W'(1);
    step_nxt   = cyc_end ? step_q + STEP_W'(1) : step_q;
    digit_nxt  = slot_end ? digit_q + DIGIT_W'(1) : digit_q;
  end

  // Shadow registers capture the slot's inputs on its first cycle
  always_comb begin
    sh_code_nxt   = slot_start ? code_q[digit_q] : sh_code_q;
    sh_bright_nxt = slot_start ? brightness      : sh_bright_q;
    sh_blank_nxt  = slot_start ? blank_live      : sh_blank_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GUARD;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    an_d      = '0;
    ca_d      = '0;
    tick_d    = (step_nxt == STEP_W'(PWM_STEPS - 1)) && (cyc_nxt == CNT_W'(SUB_DIV - 1));
    if (cyc_end) begin
      if (step_nxt == '0) begin
        state_nxt = GUARD;
      end else begin
        case (state_q)
          GUARD:   state_nxt = ((sh_bright_nxt == '0) || sh_blank_nxt) ? OFF : ON;
          ON:      if (step_q == sh_bright_nxt) state_nxt = OFF;
          default: state_nxt = state_q;
        endcase
      end
    end
    if (state_nxt == ON) begin
      an_d = NUM_DIGITS'(1) << digit_nxt;
      ca_d = sh_code_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q       <= '0;
      step_q      <= '0;
      digit_q     <= '0;
      sh_code_q   <= '0;
      sh_bright_q <= '0;
      sh_blank_q  <= 1'b0;
      an          <= '0;
      ca          <= '0;
      slot_tick   <= 1'b0;
    end else begin
      cyc_q       <= cyc_nxt;
      step_q      <= step_nxt;
      digit_q     <= digit_nxt;
      sh_code_q   <= sh_code_nxt;
      sh_bright_q <= sh_bright_nxt;
      sh_blank_q  <= sh_blank_nxt;
      an          <= an_d;
      ca          <= ca_d;
      slot_tick   <= tick_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: per-slot display records and grant order.
module tb_seg_scan_ctrl;

  localparam int SUB_DIV  = 4;
  localparam int SLOT_LEN = 16 * SUB_DIV;

  typedef struct {
    int         digit;
    int         lit;
    logic [7:0] code;
  } slot_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       p0_valid, p0_ready, p1_valid, p1_ready;
  logic [1:0] p0_digit, p1_digit;
  logic [7:0] p0_code, p1_code;
  logic [3:0] brightness, blank_mask;
  logic [3:0] an;
  logic [7:0] ca;
  logic       slot_tick;
`ifdef SEG_BLINK_EN
  logic [3:0] blink_mask = 4'b0000;
`endif

  int errors = 0;
  int checks = 0;

  slot_t sb_q[$];
  int    gq[$];
  slot_t e;
  int    slot_no = 0;
  int    pos = 0, lit_n = 0, guard_n = 0, an_err = 0, ca_err = 0;

  seg_scan_ctrl #(.SUB_DIV(SUB_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef SEG_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .p0_valid   (p0_valid),
    .p0_ready   (p0_ready),
    .p0_digit   (p0_digit),
    .p0_code    (p0_code),
    .p1_valid   (p1_valid),
    .p1_ready   (p1_ready),
    .p1_digit   (p1_digit),
    .p1_code    (p1_code),
    .brightness (brightness),
    .blank_mask (blank_mask),
    .an         (an),
    .ca         (ca),
    .slot_tick  (slot_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push_slot(input int d, input int lit, input logic [7:0] code);
    slot_t s;
    s.digit = d;
    s.lit   = lit;
    s.code  = code;
    sb_q.push_back(s);
  endtask

  task automatic tick_wait();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!slot_tick && n < 200);
    if (!slot_tick) chk("slot_tick_timeout", 0, 1);
  endtask

  task automatic drive(input logic v0, input logic [1:0] d0, input logic [7:0] c0,
                       input logic v1, input logic [1:0] d1, input logic [7:0] c1,
                       input int cycles);
    p0_valid = v0; p0_digit = d0; p0_code = c0;
    p1_valid = v1; p1_digit = d1; p1_code = c1;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
    p0_valid = 1'b0;
    p1_valid = 1'b0;
  endtask

  // Monitor: grant order, per-slot lit time, code, guard and slot length
  always @(negedge clk) begin
    if (!rst_n) begin
      pos = 0; lit_n = 0; guard_n = 0; an_err = 0; ca_err = 0;
    end else begin
      if (p0_valid || p1_valid) chk("ready_exclusive", int'(p0_ready && p1_ready), 0);
      if (p0_valid && p0_ready) begin
        if (gq.size() == 0) chk("unexpected_grant_p0", 1, 0);
        else chk("grant_port", 0, gq.pop_front());
      end
      if (p1_valid && p1_ready) begin
        if (gq.size() == 0) chk("unexpected_grant_p1", 1, 0);
        else chk("grant_port", 1, gq.pop_front());
      end
      if (an != 4'b0000) begin
        lit_n++;
        if (pos < SUB_DIV) guard_n++;
        if (sb_q.size() > 0) begin
          if (an != (4'(1) << sb_q[0].digit)) an_err++;
          if (ca != sb_q[0].code) ca_err++;
        end
      end else if (ca != 8'h00) begin
        ca_err++;
      end
      pos++;
      if (slot_tick) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("slot%0d_lit_cycles", slot_no), lit_n, e.lit * SUB_DIV);
          chk($sformatf("slot%0d_length", slot_no), pos, SLOT_LEN);
          chk($sformatf("slot%0d_guard_dark", slot_no), guard_n, 0);
          chk($sformatf("slot%0d_an_errors", slot_no), an_err, 0);
          chk($sformatf("slot%0d_ca_errors", slot_no), ca_err, 0);
        end
        slot_no++;
        pos = 0; lit_n = 0; guard_n = 0; an_err = 0; ca_err = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_k;
    logic [3:0] first_an;
    rst_n = 1'b0;
    p0_valid = 1'b0; p0_digit = 2'd0; p0_code = 8'h00;
    p1_valid = 1'b0; p1_digit = 2'd0; p1_code = 8'h00;
    brightness = 4'd15;
    blank_mask = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_an", int'(an), 0);
    chk("reset_ca", int'(ca), 0);
    chk("reset_slot_tick", int'(slot_tick), 0);
    chk("reset_p0_ready", int'(p0_ready), 0);
    chk("reset_p1_ready", int'(p1_ready), 0);

    // Slot 0 shows the reset code; later slots show the writes below
    push_slot(0, 15, 8'h00);
    push_slot(1, 15, 8'h3C);
    push_slot(2, 15, 8'hC0);
    push_slot(3, 15, 8'h5A);
    rst_n = 1'b1;
    @(posedge clk); #1;

    gq.push_back(0); gq.push_back(1); gq.push_back(0); gq.push_back(1);
    drive(1'b1, 2'd2, 8'hC0, 1'b1, 2'd3, 8'h5A, 4);
    gq.push_back(1);
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'h3C, 1);
    gq.push_back(0);
    drive(1'b1, 2'd0, 8'h81, 1'b0, 2'd0, 8'h00, 1);
    gq.push_back(1);
    drive(1'b1, 2'd0, 8'hFF, 1'b1, 2'd0, 8'h11, 1);

    repeat (4) tick_wait();
    brightness = 4'd3;
    push_slot(0, 3, 8'h11);
    push_slot(1, 3, 8'h3C);
    push_slot(2, 3, 8'hC0);
    push_slot(3, 3, 8'h5A);

    repeat (4) tick_wait();
    brightness = 4'd0;
    push_slot(0, 0, 8'h11);
    push_slot(1, 0, 8'h3C);
    push_slot(2, 0, 8'hC0);
    push_slot(3, 0, 8'h5A);

    repeat (4) tick_wait();
    brightness = 4'd15;
    blank_mask = 4'b0010;
    push_slot(0, 15, 8'h11);
    push_slot(1, 0,  8'h3C);
    push_slot(2, 15, 8'hC0);
    push_slot(3, 15, 8'h5A);

    // Rewrite digit 2 while it is lit; it must keep showing C0 this slot
    repeat (2) tick_wait();
    repeat (24) begin
      @(posedge clk); #1;
    end
    gq.push_back(0);
    drive(1'b1, 2'd2, 8'h77, 1'b0, 2'd0, 8'h00, 1);

    repeat (2) tick_wait();
    blank_mask = 4'b0000;
    push_slot(0, 15, 8'h11);
    push_slot(1, 15, 8'h3C);
    push_slot(2, 15, 8'h77);
    push_slot(3, 15, 8'h5A);

    repeat (4) tick_wait();
    repeat (30) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_an", int'(an), 1);
    chk("pre_reset_ca", int'(ca), 8'h11);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_an", int'(an), 0);
    chk("async_reset_ca", int'(ca), 0);

    brightness = 4'd3;
    push_slot(0, 3, 8'h00);
    push_slot(1, 3, 8'h42);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    first_k = -1;
    first_an = 4'b0000;
    for (int k = 1; k <= 2 * SUB_DIV; k++) begin
      @(posedge clk); #1;
      if (an != 4'b0000 && first_k < 0) begin
        first_k = k;
        first_an = an;
      end
    end
    chk("first_lit_cycle", first_k, SUB_DIV);
    chk("first_lit_an", int'(first_an), 1);

    // Pointer must be back at port 0 after reset
    gq.push_back(0);
    drive(1'b1, 2'd1, 8'h42, 1'b1, 2'd3, 8'h99, 1);

    repeat (2) tick_wait();
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("sb_leftover", sb_q.size(), 0);
    chk("grant_leftover", gq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
